sequenciador_multiciclo: RTL and testbench
==========================================

Name: sequenciador_multiciclo

Overview:
- Parametrised control FSM for the multicycle RISC-V datapath (lw, sw, sub, xor, addi, srl, beq).
- Replaces the fixed IF/ID/EX/AUX/MEM/WB/SUMPC/FIM sequencer in the top level with configurable wait depths, a memory-ready handshake with timeout, a stall input, an optional MEM bypass for non-memory opcodes, and a retired-instruction counter.
- Drives the `estado` bus consumed by all datapath modules, plus per-stage enable strobes.

Parameters:
- EX_WAIT, 2: wait cycles after EX (0 = none).
- WB_WAIT, 2: wait cycles after WB (0 = none).
- MEM_TIMEOUT, 16: maximum MEM cycles of a memory op without mem_ready before error; must be ≥ 1.
- SKIP_MEM, 0: 1 = non-load/store opcodes go EX_WAIT→WB, skipping MEM.
- CNT_W, 16: instr_count width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- instrucao  in  32  current instruction, valid from ID onward.
- stall  in  1  freeze request.
- mem_ready  in  1  data memory completion for lw/sw.
- estado  out  4  state code.
- en_if, en_id, en_ex, en_mem, en_wb, en_pc  out  1 each  stage strobes.
- fim  out  1  halted.
- erro  out  1  halted due to memory timeout.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset:
  - Sampled on posedge clk.
  - estado=IF, wait counter=0, timeout counter=0, instr_count=0, fim=0, erro=0.
  - rst wins over every other input, including mid-MEM, during stall, and in FIM.
- State codes (unchanged, datapath decodes these): IF=0000, ID=0001, EX=0010, MEM=0011, WB=0100, EX_WAIT=0101, WB_WAIT=0110, SUMPC=1000, FIM=1001.
- Transitions (stall=0):
  - IF→ID.
  - ID→FIM if instrucao==0, else →EX.
  - EX→EX_WAIT if EX_WAIT>0, else →next.
  - EX_WAIT holds EX_WAIT cycles (down-counter), then →next.
  - next = WB when SKIP_MEM=1 and opcode (instrucao[6:0]) ∉ {0000011, 0100011}; otherwise next = MEM.
  - MEM, non-memory op: exactly 1 cycle, →WB.
  - MEM, memory op: leave to WB on the edge where mem_ready=1.
  - MEM timeout: if MEM_TIMEOUT cycles elapse with mem_ready=0 → FIM, erro=1. Ready in cycle MEM_TIMEOUT still wins.
  - WB→WB_WAIT if WB_WAIT>0, else →SUMPC.
  - WB_WAIT holds WB_WAIT cycles, then →SUMPC.
  - SUMPC→IF, and instr_count increments (saturates at all-ones).
  - FIM is absorbing until rst; fim=1. erro=0 on zero-instruction halt.
- Stall:
  - While stall=1 in any state except FIM: state, wait counter, timeout counter and instr_count are held.
  - All en_* are forced to 0.
  - FIM ignores stall.
- Strobes: combinational from registered estado and stall.
  - en_X = (estado==X) & ~stall.
  - en_mem is high every unstalled MEM cycle (request held until ready).
  - All strobes are 0 in wait states and FIM.
- Default timing: defaults, mem_ready=1, no stall → 10 cycles per instruction: IF, ID, EX, W, W, MEM, WB, W, W, SUMPC.
- Simultaneous events:
  - stall=1 together with mem_ready=1 in MEM → hold; the ready is not consumed.
  - The wait counter reloads on every entry to a wait state.

Test Plan:
- rst high 3 cycles, then addi x1,x0,5 (0x00500093), defaults, mem_ready=1 → estado sequence 0,1,2,5,5,3,4,6,6,8; back to IF on cycle 10; instr_count=1; fim=0.
- Instruction 0x00000000 after reset → IF, ID, FIM on the 3rd edge; fim=1, erro=0, instr_count=0; estado stays 1001 for 20 further cycles.
- lw (0x0000A103), mem_ready low for 4 MEM cycles then high → MEM lasts 5 cycles with en_mem=1 throughout; then WB; total 14 cycles.
- sw (0x0020A023), MEM_TIMEOUT=4, mem_ready=0 → FIM after 4 MEM cycles; erro=1, fim=1; instr_count unchanged.
- SKIP_MEM=1, EX_WAIT=0, WB_WAIT=0, sub (0x40208033) → IF, ID, EX, WB, SUMPC: 5 cycles. Same config with lw → 6 cycles including MEM.
- stall=1 for 3 cycles during EX_WAIT and 2 cycles in MEM (mem_ready=1) → instruction takes 15 cycles; all en_* low while stalled. Then rst asserted mid-WB → estado=IF and instr_count=0 next cycle.

Source files
------------

// File: rtl/sequenciador_multiciclo.sv
// Control sequencer for the multicycle RISC-V datapath: drives the estado bus,
// per-stage strobes, a memory-ready handshake with timeout, and a retired counter.
module sequenciador_multiciclo #(
  parameter int EX_WAIT     = 2,
  parameter int WB_WAIT     = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int SKIP_MEM    = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instrucao,
  input  logic             stall,
  input  logic             mem_ready,
  output logic [3:0]       estado,
  output logic             en_if,
  output logic             en_id,
  output logic             en_ex,
  output logic             en_mem,
  output logic             en_wb,
  output logic             en_pc,
  output logic             fim,
  output logic             erro,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IF      = 4'b0000,
    S_ID      = 4'b0001,
    S_EX      = 4'b0010,
    S_MEM     = 4'b0011,
    S_WB      = 4'b0100,
    S_EX_WAIT = 4'b0101,
    S_WB_WAIT = 4'b0110,
    S_SUMPC   = 4'b1000,
    S_FIM     = 4'b1001
  } state_t;

  localparam int WAIT_MAX = (EX_WAIT > WB_WAIT) ? EX_WAIT : WB_WAIT;
  localparam int WAIT_W   = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam int TMO_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  // Wait counters are loaded with N-1 so a wait state lasts exactly N cycles.
  localparam logic [WAIT_W-1:0] EX_LOAD  = WAIT_W'((EX_WAIT > 0) ? EX_WAIT - 1 : 0);
  localparam logic [WAIT_W-1:0] WB_LOAD  = WAIT_W'((WB_WAIT > 0) ? WB_WAIT - 1 : 0);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              erro_q, erro_d;
  logic              is_mem;
  state_t            after_ex;

  assign is_mem   = (instrucao[6:0] == 7'b0000011) || (instrucao[6:0] == 7'b0100011);
  assign after_ex = ((SKIP_MEM != 0) && !is_mem) ? S_WB : S_MEM;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    erro_d  = erro_q;
    if (!stall) begin
      case (state_q)
        S_IF: state_d = S_ID;
        S_ID: state_d = (instrucao == 32'd0) ? S_FIM : S_EX;
        S_EX: begin
          if (EX_WAIT > 0) begin
            state_d = S_EX_WAIT;
            wait_d  = EX_LOAD;
          end else begin
            state_d = after_ex;
            tmo_d   = '0;
          end
        end
        S_EX_WAIT: begin
          if (wait_q == '0) begin
            state_d = after_ex;
            tmo_d   = '0;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
        // A ready arriving in the last allowed cycle still completes the access.
        S_MEM: begin
          if (!is_mem || mem_ready) begin
            state_d = S_WB;
          end else if (tmo_q == TMO_LAST) begin
            state_d = S_FIM;
            erro_d  = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        S_WB: begin
          if (WB_WAIT > 0) begin
            state_d = S_WB_WAIT;
            wait_d  = WB_LOAD;
          end else begin
            state_d = S_SUMPC;
          end
        end
        S_WB_WAIT: begin
          if (wait_q == '0) state_d = S_SUMPC;
          else              wait_d  = wait_q - WAIT_W'(1);
        end
        S_SUMPC: begin
          state_d = S_IF;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      wait_q  <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      erro_q  <= erro_d;
    end
  end

  assign estado      = state_q;
  assign en_if       = (state_q == S_IF)    && !stall;
  assign en_id       = (state_q == S_ID)    && !stall;
  assign en_ex       = (state_q == S_EX)    && !stall;
  assign en_mem      = (state_q == S_MEM)   && !stall;
  assign en_wb       = (state_q == S_WB)    && !stall;
  assign en_pc       = (state_q == S_SUMPC) && !stall;
  assign fim         = (state_q == S_FIM);
  assign erro        = erro_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Bench for sequenciador_multiciclo: three configurations side by side, a
// directed vector table, multi-cycle corner sequences and a random phase.
module tb_sequenciador_multiciclo;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_SUB  = 32'h40208033;
  localparam logic [31:0] I_XOR  = 32'h0020C1B3;
  localparam logic [31:0] I_SRL  = 32'h0020D1B3;
  localparam logic [31:0] I_BEQ  = 32'h00208463;

  logic        clk, rst, stall, mem_ready;
  logic [31:0] instr_v [3];
  logic [3:0]  st [3];
  logic        en_if [3], en_id [3], en_ex [3], en_mem [3], en_wb [3], en_pc [3];
  logic        fim_v [3], erro_v [3];
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance 0: defaults. Instance 1: short timeout. Instance 2: MEM skip, no waits, 2-bit counter.
  sequenciador_multiciclo u_def (
    .clk(clk), .rst(rst), .instrucao(instr_v[0]), .stall(stall), .mem_ready(mem_ready),
    .estado(st[0]), .en_if(en_if[0]), .en_id(en_id[0]), .en_ex(en_ex[0]), .en_mem(en_mem[0]),
    .en_wb(en_wb[0]), .en_pc(en_pc[0]), .fim(fim_v[0]), .erro(erro_v[0]), .instr_count(cnt0));

  sequenciador_multiciclo #(.MEM_TIMEOUT(4)) u_tmo (
    .clk(clk), .rst(rst), .instrucao(instr_v[1]), .stall(stall), .mem_ready(mem_ready),
    .estado(st[1]), .en_if(en_if[1]), .en_id(en_id[1]), .en_ex(en_ex[1]), .en_mem(en_mem[1]),
    .en_wb(en_wb[1]), .en_pc(en_pc[1]), .fim(fim_v[1]), .erro(erro_v[1]), .instr_count(cnt1));

  sequenciador_multiciclo #(.SKIP_MEM(1), .EX_WAIT(0), .WB_WAIT(0), .CNT_W(2)) u_skip (
    .clk(clk), .rst(rst), .instrucao(instr_v[2]), .stall(stall), .mem_ready(mem_ready),
    .estado(st[2]), .en_if(en_if[2]), .en_id(en_id[2]), .en_ex(en_ex[2]), .en_mem(en_mem[2]),
    .en_wb(en_wb[2]), .en_pc(en_pc[2]), .fim(fim_v[2]), .erro(erro_v[2]), .instr_count(cnt2));

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  // Each instruction is turned into a plan (list of states after EX) when it is
  // decoded; the model then walks the plan, stretching MEM while ready is low.
  int p_exw  [3] = '{2, 2, 0};
  int p_wbw  [3] = '{2, 2, 0};
  int p_tmo  [3] = '{16, 4, 16};
  int p_skip [3] = '{0, 0, 1};
  int p_cmax [3] = '{65535, 65535, 3};

  int m_cur [3], m_cnt [3], m_mcyc [3], m_pos [3], m_len [3];
  int m_plan [3][16];
  bit m_err [3];
  bit m_valid = 1'b0;

  task automatic push_plan(input int k, input int code);
    m_plan[k][m_len[k]] = code;
    m_len[k]++;
  endtask

  task automatic model_step(input int k);
    bit memop;
    memop = (instr_v[k][6:0] == 7'h03) || (instr_v[k][6:0] == 7'h23);
    if (rst) begin
      m_cur[k] = 0; m_cnt[k] = 0; m_err[k] = 1'b0;
      m_mcyc[k] = 0; m_len[k] = 0; m_pos[k] = 0;
    end else if (m_cur[k] == 9 || stall) begin
      m_cur[k] = m_cur[k];
    end else if (m_cur[k] == 0) begin
      m_cur[k] = 1;
    end else if (m_cur[k] == 1) begin
      if (instr_v[k] == 32'd0) m_cur[k] = 9;
      else begin
        m_len[k] = 0;
        m_pos[k] = 0;
        repeat (p_exw[k]) push_plan(k, 5);
        if (!(p_skip[k] != 0 && !memop)) push_plan(k, 3);
        push_plan(k, 4);
        repeat (p_wbw[k]) push_plan(k, 6);
        push_plan(k, 8);
        m_cur[k] = 2;
      end
    end else if (m_cur[k] == 3 && memop && !mem_ready) begin
      m_mcyc[k]++;
      if (m_mcyc[k] == p_tmo[k]) begin
        m_cur[k] = 9;
        m_err[k] = 1'b1;
      end
    end else if (m_cur[k] == 8) begin
      if (m_cnt[k] < p_cmax[k]) m_cnt[k]++;
      m_cur[k] = 0;
    end else begin
      m_cur[k] = m_plan[k][m_pos[k]];
      m_pos[k]++;
      m_mcyc[k] = 0;
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int get_cnt(input int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic logic [5:0] en_vec(input int k);
    return {en_if[k], en_id[k], en_ex[k], en_mem[k], en_wb[k], en_pc[k]};
  endfunction

  task automatic check_all();
    logic [5:0] exp_en;
    for (int k = 0; k < 3; k++) begin
      exp_en = {m_cur[k] == 0, m_cur[k] == 1, m_cur[k] == 2,
                m_cur[k] == 3, m_cur[k] == 4, m_cur[k] == 8} & {6{~stall}};
      cmp($sformatf("model_estado[%0d]", k), int'(st[k]), m_cur[k]);
      cmp($sformatf("model_en[%0d]", k), int'(en_vec(k)), int'(exp_en));
      cmp($sformatf("model_fim[%0d]", k), int'(fim_v[k]), int'(m_cur[k] == 9));
      cmp($sformatf("model_erro[%0d]", k), int'(erro_v[k]), int'(m_err[k]));
      cmp($sformatf("model_count[%0d]", k), get_cnt(k), m_cnt[k]);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    if (rst) m_valid = 1'b1;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    if (m_valid) check_all();
    edge_step();
  endtask

  task automatic set_instr(input logic [31:0] ins);
    for (int k = 0; k < 3; k++) instr_v[k] = ins;
  endtask

  task automatic reset_dut();
    rst = 1'b1; stall = 1'b0; mem_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic        stl;
    logic        rdy;
    logic [3:0]  st;
    logic [5:0]  en;
    logic        fim;
    logic        err;
    int          cnt;
  } vec_t;

  vec_t vt [18];
  logic [31:0] pool [8];

  initial begin
    int len;
    pool = '{I_ADDI, I_LW, I_SW, I_SUB, I_XOR, I_SRL, I_BEQ, 32'd0};

    // rst, instr, stall, ready | estado, {if,id,ex,mem,wb,pc}, fim, erro, count
    vt[0]  = '{1'b0, I_ADDI, 1'b0, 1'b1, 4'h0, 6'b100000, 1'b0, 1'b0, 0};
    vt[1]  = '{1'b0, I_ADDI, 1'b0, 1'b1, 4'h1, 6'b010000, 1'b0, 1'b0, 0};
    vt[2]  = '{1'b0, I_ADDI, 1'b0, 1'b1, 4'h2, 6'b001000, 1'b0, 1'b0, 0};
    vt[3]  = '{1'b0, I_ADDI, 1'b0, 1'b1, 4'h5, 6'b000000, 1'b0, 1'b0, 0};
    vt[4]  = '{1'b0, I_ADDI, 1'b0, 1'b1, 4'h5, 6'b000000, 1'b0, 1'b0, 0};
    vt[5]  = '{1'b0, I_ADDI, 1'b0, 1'b1, 4'h3, 6'b000100, 1'b0, 1'b0, 0};
    vt[6]  = '{1'b0, I_ADDI, 1'b0, 1'b1, 4'h4, 6'b000010, 1'b0, 1'b0, 0};
    vt[7]  = '{1'b0, I_ADDI, 1'b0, 1'b1, 4'h6, 6'b000000, 1'b0, 1'b0, 0};
    vt[8]  = '{1'b0, I_ADDI, 1'b0, 1'b1, 4'h6, 6'b000000, 1'b0, 1'b0, 0};
    vt[9]  = '{1'b0, I_ADDI, 1'b0, 1'b1, 4'h8, 6'b000001, 1'b0, 1'b0, 0};
    vt[10] = '{1'b0, I_ADDI, 1'b0, 1'b1, 4'h0, 6'b100000, 1'b0, 1'b0, 1};
    vt[11] = '{1'b0, 32'd0,  1'b0, 1'b1, 4'h1, 6'b010000, 1'b0, 1'b0, 1};
    vt[12] = '{1'b0, 32'd0,  1'b0, 1'b1, 4'h9, 6'b000000, 1'b1, 1'b0, 1};
    vt[13] = '{1'b1, 32'd0,  1'b0, 1'b1, 4'h9, 6'b000000, 1'b1, 1'b0, 1};
    vt[14] = '{1'b0, 32'd0,  1'b0, 1'b1, 4'h0, 6'b100000, 1'b0, 1'b0, 0};
    vt[15] = '{1'b0, 32'd0,  1'b0, 1'b1, 4'h1, 6'b010000, 1'b0, 1'b0, 0};
    vt[16] = '{1'b0, 32'd0,  1'b0, 1'b1, 4'h9, 6'b000000, 1'b1, 1'b0, 0};
    vt[17] = '{1'b0, 32'd0,  1'b1, 1'b0, 4'h9, 6'b000000, 1'b1, 1'b0, 0};

    rst = 1'b1; stall = 1'b0; mem_ready = 1'b1;
    set_instr(I_ADDI);
    repeat (3) edge_step();

    for (int i = 0; i < 18; i++) begin
      rst = vt[i].rst; stall = vt[i].stl; mem_ready = vt[i].rdy;
      set_instr(vt[i].ins);
      @(negedge clk);
      cmp($sformatf("vec%0d_estado", i), int'(st[0]), int'(vt[i].st));
      cmp($sformatf("vec%0d_en", i), int'(en_vec(0)), int'(vt[i].en));
      cmp($sformatf("vec%0d_fim", i), int'(fim_v[0]), int'(vt[i].fim));
      cmp($sformatf("vec%0d_erro", i), int'(erro_v[0]), int'(vt[i].err));
      cmp($sformatf("vec%0d_count", i), int'(cnt0), vt[i].cnt);
      check_all();
      edge_step();
    end

    // Halt is absorbing, stall or not.
    for (int i = 0; i < 20; i++) begin
      stall = 1'(($urandom_range(0, 1)));
      tick();
      cmp("fim_absorbing", int'(st[0]), 9);
    end

    // lw with ready low for 4 MEM cycles: MEM lasts 5 cycles, 14 in total.
    reset_dut();
    set_instr(I_LW);
    len = 0;
    do begin
      mem_ready = !(len >= 5 && len <= 8);
      tick();
      len++;
    end while (st[0] != 4'h0 && len < 40);
    cmp("lw_cycles", len, 14);
    cmp("lw_count", int'(cnt0), 1);

    // sw with no ready on the short-timeout instance: FIM after 4 MEM cycles.
    reset_dut();
    set_instr(I_SW);
    mem_ready = 1'b0;
    len = 0;
    do begin
      tick();
      len++;
    end while (!fim_v[1] && len < 40);
    cmp("sw_timeout_cycles", len, 9);
    cmp("sw_timeout_erro", int'(erro_v[1]), 1);
    cmp("sw_timeout_count", int'(cnt1), 0);

    // MEM skip: sub takes 5 cycles, lw still visits MEM for 6.
    reset_dut();
    set_instr(I_SUB);
    len = 0;
    do begin tick(); len++; end while (st[2] != 4'h0 && len < 40);
    cmp("skip_sub_cycles", len, 5);
    set_instr(I_LW);
    len = 0;
    do begin tick(); len++; end while (st[2] != 4'h0 && len < 40);
    cmp("skip_lw_cycles", len, 6);
    cmp("skip_count", int'(cnt2), 2);

    // Stall 3 cycles in EX_WAIT and 2 in MEM: 15 cycles; then reset mid-WB.
    reset_dut();
    set_instr(I_ADDI);
    len = 0;
    do begin
      stall = (len == 3 || len == 4 || len == 5 || len == 8 || len == 9);
      tick();
      len++;
    end while (st[0] != 4'h0 && len < 40);
    stall = 1'b0;
    cmp("stall_cycles", len, 15);
    repeat (6) tick();
    cmp("mid_wb_estado", int'(st[0]), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("rst_mid_wb_estado", int'(st[0]), 0);
    cmp("rst_mid_wb_count", int'(cnt0), 0);

    // Random phase against the model.
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 3; k++)
        if (m_cur[k] == 0) instr_v[k] = pool[($urandom_range(0, 20) == 0) ? 7 : $urandom_range(0, 6)];
      stall     = ($urandom_range(0, 9) < 2);
      mem_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 149) == 0) ||
                  (m_cur[0] == 9 && m_cur[1] == 9 && m_cur[2] == 9);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
